// File: rtl/mda_vram_port.sv
// VRAM SRAM port for the MDA/Hercules sequencer: display fetches take the pins
// combinationally from the slot strobes, CPU accesses run a 3-cycle FSM in ISA slots.
module mda_vram_port #(
  parameter int VRAM_AW = 15
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               vram_read,
  input  logic               vram_read_a0,
  input  logic               vram_read_char,
  input  logic               vram_read_att,
  input  logic               isa_op_enable,
  input  logic [VRAM_AW-2:0] disp_addr,
  input  logic [VRAM_AW-1:0] bus_addr,
  input  logic               bus_rd_req,
  input  logic               bus_wr_req,
  input  logic [7:0]         bus_din,
  output logic [7:0]         bus_dout,
  output logic               bus_ack,
  output logic [VRAM_AW-1:0] ram_a,
  input  logic [7:0]         ram_d_in,
  output logic [7:0]         ram_d_out,
  output logic               ram_d_oe,
  output logic               ram_oe_l,
  output logic               ram_we_l,
  output logic [7:0]         char_byte,
  output logic [7:0]         att_byte,
  output logic               fetch_valid
);

  typedef enum logic [1:0] {IDLE, ADDR, STROBE, FINISH} state_t;

  state_t             state, state_nxt;
  logic [VRAM_AW-1:0] op_addr;
  logic [7:0]         op_data;
  logic               op_wr;
  logic               start;
  logic               op_done;

  // bus_ack is still high on the cycle after FINISH; a held request must not restart then
  assign start   = (state == IDLE) && isa_op_enable && !vram_read &&
                   (bus_wr_req || bus_rd_req) && !bus_ack;
  assign op_done = (state == FINISH) && !vram_read;

  assign ram_d_out = op_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_addr <= '0;
      op_data <= '0;
      op_wr   <= 1'b0;
    end else if (start) begin
      op_addr <= bus_addr;
      op_data <= bus_din;
      op_wr   <= bus_wr_req;
    end
  end

  // Pin control is combinational and gated by reset_n so a reset mid-write
  // releases WE and the data drivers without waiting for a clock edge.
  always_comb begin
    state_nxt = state;
    ram_a     = '0;
    ram_oe_l  = 1'b1;
    ram_we_l  = 1'b1;
    ram_d_oe  = 1'b0;
    case (state)
      IDLE:    if (start) state_nxt = ADDR;
      ADDR:    state_nxt = vram_read ? IDLE : STROBE;
      STROBE:  state_nxt = vram_read ? IDLE : FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (reset_n) begin
      if (vram_read) begin
        ram_a    = {disp_addr, vram_read_a0};
        ram_oe_l = 1'b0;
      end else if (state != IDLE) begin
        ram_a = op_addr;
        if (op_wr) begin
          ram_d_oe = 1'b1;
          ram_we_l = (state != STROBE);
        end else begin
          ram_oe_l = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus_ack  <= 1'b0;
      bus_dout <= '0;
    end else begin
      bus_ack <= op_done;
      if (op_done && !op_wr) bus_dout <= ram_d_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      char_byte   <= '0;
      att_byte    <= '0;
      fetch_valid <= 1'b0;
    end else begin
      if (vram_read_char) char_byte <= ram_d_in;
      if (vram_read_att)  att_byte  <= ram_d_in;
      fetch_valid <= vram_read_att;
    end
  end

endmodule

// File: tb/tb_mda_vram_port.sv
// Bench for mda_vram_port: text-mode sequencer model (18 slots), SRAM model,
// table-driven display/ISA vectors and an ISA scoreboard popped on bus_ack.
module tb_mda_vram_port;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        vram_read, vram_read_a0, vram_read_char, vram_read_att, isa_op_enable;
  logic [13:0] disp_addr;
  logic [14:0] bus_addr;
  logic        bus_rd_req, bus_wr_req;
  logic [7:0]  bus_din, bus_dout;
  logic        bus_ack;
  logic [14:0] ram_a;
  logic [7:0]  ram_d_in, ram_d_out;
  logic        ram_d_oe, ram_oe_l, ram_we_l;
  logic [7:0]  char_byte, att_byte;
  logic        fetch_valid;

  int errors = 0;
  int checks = 0;
  int slot = 0;
  int we_cnt = 0;
  logic extra_rd;

  logic [7:0]  mem [0:32767];
  logic        pl_en;
  logic [14:0] pl_addr;
  logic [7:0]  pl_data;

  typedef struct {
    logic        wr;
    logic [14:0] addr;
    logic [7:0]  din;
    logic [7:0]  dout;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic [13:0] addr;
    logic [7:0]  ch;
    logic [7:0]  at;
  } disp_vec_t;

  typedef struct {
    logic        wr;
    logic [14:0] addr;
    logic [7:0]  din;
    logic [7:0]  dout;
    int          start;
    int          ack_slot;
  } isa_vec_t;

  disp_vec_t dtab[4];
  isa_vec_t  itab[6];

  mda_vram_port #(.VRAM_AW(15)) dut (
    .clk(clk), .reset_n(reset_n),
    .vram_read(vram_read), .vram_read_a0(vram_read_a0),
    .vram_read_char(vram_read_char), .vram_read_att(vram_read_att),
    .isa_op_enable(isa_op_enable), .disp_addr(disp_addr),
    .bus_addr(bus_addr), .bus_rd_req(bus_rd_req), .bus_wr_req(bus_wr_req),
    .bus_din(bus_din), .bus_dout(bus_dout), .bus_ack(bus_ack),
    .ram_a(ram_a), .ram_d_in(ram_d_in), .ram_d_out(ram_d_out),
    .ram_d_oe(ram_d_oe), .ram_oe_l(ram_oe_l), .ram_we_l(ram_we_l),
    .char_byte(char_byte), .att_byte(att_byte), .fetch_valid(fetch_valid)
  );

  always #5 clk = ~clk;

  // Text-mode sequencer: char fetch slot 3, attribute fetch slot 4, ISA window 6..14
  always @(posedge clk) slot <= (slot == 17) ? 0 : slot + 1;
  assign vram_read      = (slot == 3) || (slot == 4) || extra_rd;
  assign vram_read_a0   = (slot == 4);
  assign vram_read_char = (slot == 3);
  assign vram_read_att  = (slot == 4);
  assign isa_op_enable  = (slot >= 6) && (slot <= 14);

  // SRAM model
  assign ram_d_in = ram_oe_l ? 8'hEE : mem[ram_a];
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (!ram_we_l && ram_d_oe) mem[ram_a] <= ram_d_out;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_slot(input int n);
    bit hit = 0;
    for (int k = 0; k < 40 && !hit; k++) begin
      @(negedge clk);
      if (slot == n) hit = 1;
    end
    check("slot_reached", hit, 1);
  endtask

  task automatic wait_ack(output int s);
    bit hit = 0;
    s = -1;
    for (int k = 0; k < 80 && !hit; k++) begin
      @(posedge clk);
      #1;
      if (bus_ack) begin
        hit = 1;
        s = slot;
      end
    end
    check("ack_seen", hit, 1);
  endtask

  task automatic preload(input logic [14:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    @(negedge clk);
    pl_en   = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_dout"}, bus_dout, 0);
    check({tag, "_ack"}, bus_ack, 0);
    check({tag, "_char"}, char_byte, 0);
    check({tag, "_att"}, att_byte, 0);
    check({tag, "_fv"}, fetch_valid, 0);
    check({tag, "_we"}, ram_we_l, 1);
    check({tag, "_oe"}, ram_oe_l, 1);
    check({tag, "_doe"}, ram_d_oe, 0);
    check({tag, "_a"}, ram_a, 0);
    check({tag, "_dout_ram"}, ram_d_out, 0);
  endtask

  task automatic do_op(input isa_vec_t v);
    int s;
    wait_slot(v.start);
    bus_addr = v.addr;
    bus_din  = v.wr ? v.din : 8'h5C;
    sb.push_back('{v.wr, v.addr, v.din, v.dout});
    if (v.wr) bus_wr_req = 1'b1;
    else      bus_rd_req = 1'b1;
    wait_ack(s);
    check(v.wr ? "wr_ack_slot" : "rd_ack_slot", s, v.ack_slot);
    bus_wr_req = 1'b0;
    bus_rd_req = 1'b0;
    if (v.wr) check("mem_written", mem[v.addr], v.din);
  endtask

  // Scoreboard/pin monitor, sampled on the falling edge
  task automatic monitor();
    sb_t r;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        we_cnt = 0;
      end else begin
        if (vram_read) begin
          check("disp_we", ram_we_l, 1);
          check("disp_oe", ram_oe_l, 0);
          check("disp_doe", ram_d_oe, 0);
          check("disp_a", ram_a, {disp_addr, vram_read_a0});
        end
        if (!ram_we_l) begin
          we_cnt++;
          check("we_doe", ram_d_oe, 1);
          if (sb.size() > 0) begin
            check("we_a", ram_a, sb[0].addr);
            check("we_d", ram_d_out, sb[0].din);
          end
        end
        if (bus_ack) begin
          if (sb.size() == 0) begin
            check("ack_unexpected", sb.size(), 1);
          end else begin
            r = sb.pop_front();
            check("we_pulses", we_cnt, r.wr ? 1 : 0);
            if (!r.wr) check("rd_data", bus_dout, r.dout);
          end
          we_cnt = 0;
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int cnt;
    bit hit;
    dtab[0] = '{14'h0123, 8'h41, 8'h07};
    dtab[1] = '{14'h3FFF, 8'hFF, 8'h00};
    dtab[2] = '{14'h0000, 8'h5A, 8'hC3};
    dtab[3] = '{14'h2AAA, 8'h12, 8'h34};
    itab[0] = '{1'b1, 15'h0010, 8'hA5, 8'h00, 0, 10};
    itab[1] = '{1'b0, 15'h0010, 8'h00, 8'hA5, 0, 10};
    itab[2] = '{1'b1, 15'h7FFF, 8'h3C, 8'h00, 0, 10};
    itab[3] = '{1'b0, 15'h7FFF, 8'h00, 8'h3C, 0, 10};
    itab[4] = '{1'b1, 15'h0030, 8'h99, 8'h00, 14, 0};
    itab[5] = '{1'b0, 15'h0030, 8'h00, 8'h99, 14, 0};

    reset_n = 1'b1; disp_addr = '0; bus_addr = '0; bus_din = '0;
    bus_rd_req = 1'b0; bus_wr_req = 1'b0; extra_rd = 1'b0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    #1 reset_n = 1'b0;
    fork
      monitor();
    join_none
    repeat (6) @(negedge clk);
    chk_reset("rst");
    #2 reset_n = 1'b1;

    // Display fetches
    for (int i = 0; i < 4; i++) begin
      preload({dtab[i].addr, 1'b0}, dtab[i].ch);
      preload({dtab[i].addr, 1'b1}, dtab[i].at);
      wait_slot(0);
      disp_addr = dtab[i].addr;
      hit = 0;
      for (int k = 0; k < 40 && !hit; k++) begin
        @(negedge clk);
        if (fetch_valid) hit = 1;
      end
      check("fetch_seen", hit, 1);
      check("fetch_slot", slot, 5);
      check("char_byte", char_byte, dtab[i].ch);
      check("att_byte", att_byte, dtab[i].at);
      cnt = 0;
      hit = 0;
      for (int k = 0; k < 40 && !hit; k++) begin
        @(negedge clk);
        cnt++;
        if (fetch_valid) hit = 1;
      end
      check("fetch_period", cnt, 18);
    end

    // Single ISA ops, including ones accepted on the last window slot
    for (int i = 0; i < 6; i++) do_op(itab[i]);

    // Simultaneous read and write: write first, read in the same window
    wait_slot(0);
    bus_addr = 15'h0044; bus_din = 8'hB7;
    sb.push_back('{1'b1, 15'h0044, 8'hB7, 8'h00});
    sb.push_back('{1'b0, 15'h0044, 8'h00, 8'hB7});
    bus_wr_req = 1'b1; bus_rd_req = 1'b1;
    wait_ack(s);
    check("both_wr_slot", s, 10);
    bus_wr_req = 1'b0;
    wait_ack(s);
    check("both_rd_slot", s, 15);
    bus_rd_req = 1'b0;

    // Display steals the bus during ADDR: op abandoned and retried
    wait_slot(0);
    bus_addr = 15'h0040; bus_din = 8'h66;
    sb.push_back('{1'b1, 15'h0040, 8'h66, 8'h00});
    bus_wr_req = 1'b1;
    wait_slot(7);
    #1 extra_rd = 1'b1;
    #1;
    check("viol_a", ram_a, {disp_addr, 1'b0});
    check("viol_oe", ram_oe_l, 0);
    check("viol_doe", ram_d_oe, 0);
    @(negedge clk);
    #1 extra_rd = 1'b0;
    wait_ack(s);
    check("retry_ack_slot", s, 12);
    bus_wr_req = 1'b0;
    check("retry_mem", mem[15'h0040], 8'h66);

    // Reset asserted during the write strobe
    wait_slot(0);
    bus_addr = 15'h0020; bus_din = 8'h5A;
    sb.push_back('{1'b1, 15'h0020, 8'h5A, 8'h00});
    bus_wr_req = 1'b1;
    wait_slot(8);
    check("pre_rst_we", ram_we_l, 0);
    #2 reset_n = 1'b0;
    #1;
    check("rst_now_we", ram_we_l, 1);
    check("rst_now_doe", ram_d_oe, 0);
    repeat (20) @(negedge clk);
    chk_reset("rst_hold");
    wait_slot(10);
    #2 reset_n = 1'b1;
    #1;
    chk_reset("rst_rel");
    wait_ack(s);
    check("post_rst_ack_slot", s, 14);
    bus_wr_req = 1'b0;
    check("post_rst_mem", mem[15'h0020], 8'h5A);
    do_op('{1'b0, 15'h0020, 8'h00, 8'h5A, 0, 10});

    repeat (20) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
